// File: rtl/core_scheduler.sv
// Per-core instruction sequencer: FETCH/DECODE/REQUEST/WAIT/EXECUTE/UPDATE, owns the core PC.
// Optional WAIT-state watchdog enabled by defining SCHED_WATCHDOG_EN.
module core_scheduler #(
  parameter int unsigned THREADS     = 4,
  parameter int unsigned PC_BITS     = 8,
  parameter int unsigned WDOG_CYCLES = 255
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [THREADS-1:0]         thread_enable,
  input  logic                       fetch_valid,
  input  logic                       decoded_mem_read_enable,
  input  logic                       decoded_mem_write_enable,
  input  logic                       decoded_ret,
  input  logic [THREADS-1:0]         lsu_busy,
  input  logic [THREADS*PC_BITS-1:0] next_pc,
  output logic [2:0]                 core_state,
  output logic [PC_BITS-1:0]         current_pc,
  output logic                       done,
  output logic                       diverged,
  output logic                       watchdog_error
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_FETCH   = 3'b001,
    S_DECODE  = 3'b010,
    S_REQUEST = 3'b011,
    S_WAIT    = 3'b100,
    S_EXECUTE = 3'b101,
    S_UPDATE  = 3'b110,
    S_DONE    = 3'b111
  } state_t;

  state_t               state, state_next;
  logic [THREADS-1:0]   mask, mask_next;
  logic [PC_BITS-1:0]   pc_next;
  logic                 done_next;
  logic                 diverged_next;
  logic                 busy;
  logic [PC_BITS-1:0]   sel_pc;
  logic                 sel_found;
  logic                 pc_mismatch;

  // Memory-op flags are consumed by the LSUs; every instruction passes through WAIT anyway.
  logic unused_decode;
  assign unused_decode = decoded_mem_read_enable ^ decoded_mem_write_enable;

  assign busy       = |(lsu_busy & mask);
  assign core_state = 3'(state);

`ifdef SCHED_WATCHDOG_EN
  localparam int unsigned CNT_RAW  = $clog2(WDOG_CYCLES + 1);
  localparam int unsigned CNT_BITS = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 32) ? 32 : CNT_RAW);

  logic [CNT_BITS-1:0] wait_cnt, wait_cnt_next, wait_cnt_inc;
  logic                wdog_next;

  assign wait_cnt_inc = wait_cnt + CNT_BITS'(1);
`endif

  // Lowest-index enabled thread supplies the PC; any other enabled thread disagreeing flags divergence.
  always_comb begin
    sel_pc      = '0;
    sel_found   = 1'b0;
    pc_mismatch = 1'b0;
    for (int i = 0; i < THREADS; i++) begin
      if (mask[i] && !sel_found) begin
        sel_pc    = next_pc[i*PC_BITS +: PC_BITS];
        sel_found = 1'b1;
      end
    end
    for (int i = 0; i < THREADS; i++) begin
      if (mask[i] && (next_pc[i*PC_BITS +: PC_BITS] != sel_pc)) pc_mismatch = 1'b1;
    end
  end

  always_comb begin
    state_next    = state;
    mask_next     = mask;
    pc_next       = current_pc;
    done_next     = done;
    diverged_next = diverged;
`ifdef SCHED_WATCHDOG_EN
    wait_cnt_next = wait_cnt;
    wdog_next     = watchdog_error;
`endif
    case (state)
      S_IDLE: begin
        if (start) begin
          mask_next     = thread_enable;
          diverged_next = 1'b0;
          pc_next       = '0;
`ifdef SCHED_WATCHDOG_EN
          wdog_next     = 1'b0;
`endif
          if (thread_enable == '0) begin
            state_next = S_DONE;
            done_next  = 1'b1;
          end else begin
            state_next = S_FETCH;
            done_next  = 1'b0;
          end
        end
      end
      S_FETCH:   if (fetch_valid) state_next = S_DECODE;
      S_DECODE:  state_next = S_REQUEST;
      S_REQUEST: begin
        state_next = S_WAIT;
`ifdef SCHED_WATCHDOG_EN
        wait_cnt_next = '0;
`endif
      end
      S_WAIT: begin
`ifdef SCHED_WATCHDOG_EN
        wait_cnt_next = wait_cnt_inc;
        // A release on the same cycle the limit is hit wins over the timeout.
        if (!busy) begin
          state_next = S_EXECUTE;
        end else if (wait_cnt_inc == CNT_BITS'(WDOG_CYCLES)) begin
          state_next = S_DONE;
          done_next  = 1'b1;
          wdog_next  = 1'b1;
        end
`else
        if (!busy) state_next = S_EXECUTE;
`endif
      end
      S_EXECUTE: state_next = S_UPDATE;
      S_UPDATE: begin
        if (decoded_ret) begin
          state_next = S_DONE;
          done_next  = 1'b1;
        end else begin
          state_next = S_FETCH;
          pc_next    = sel_pc;
          if (pc_mismatch) diverged_next = 1'b1;
        end
      end
      S_DONE: begin
        done_next = 1'b1;
        if (!start) begin
          state_next = S_IDLE;
          done_next  = 1'b0;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      mask       <= '0;
      current_pc <= '0;
      done       <= 1'b0;
      diverged   <= 1'b0;
    end else begin
      state      <= state_next;
      mask       <= mask_next;
      current_pc <= pc_next;
      done       <= done_next;
      diverged   <= diverged_next;
    end
  end

`ifdef SCHED_WATCHDOG_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt       <= '0;
      watchdog_error <= 1'b0;
    end else begin
      wait_cnt       <= wait_cnt_next;
      watchdog_error <= wdog_next;
    end
  end
`else
  assign watchdog_error = 1'b0;
`endif

endmodule

// File: tb/tb_core_scheduler.sv
// Directed self-checking bench for core_scheduler (4 threads, 8-bit PC, watchdog limit 10).
module tb_core_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  thread_enable;
  logic        fetch_valid;
  logic        decoded_mem_read_enable;
  logic        decoded_mem_write_enable;
  logic        decoded_ret;
  logic [3:0]  lsu_busy;
  logic [31:0] next_pc;
  logic [2:0]  core_state;
  logic [7:0]  current_pc;
  logic        done;
  logic        diverged;
  logic        watchdog_error;

  int n_checks = 0;
  int n_errs   = 0;

  core_scheduler #(.THREADS(4), .PC_BITS(8), .WDOG_CYCLES(10)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .start                    (start),
    .thread_enable            (thread_enable),
    .fetch_valid              (fetch_valid),
    .decoded_mem_read_enable  (decoded_mem_read_enable),
    .decoded_mem_write_enable (decoded_mem_write_enable),
    .decoded_ret              (decoded_ret),
    .lsu_busy                 (lsu_busy),
    .next_pc                  (next_pc),
    .core_state               (core_state),
    .current_pc               (current_pc),
    .done                     (done),
    .diverged                 (diverged),
    .watchdog_error           (watchdog_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; thread_enable = 4'b0000; fetch_valid = 1'b1;
    decoded_mem_read_enable = 1'b0; decoded_mem_write_enable = 1'b0;
    decoded_ret = 1'b0; lsu_busy = 4'b0000; next_pc = 32'h01010101;
    tick(2);
    chk("rst_state", 32'(core_state), 32'd0);
    chk("rst_pc", 32'(current_pc), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_div", 32'(diverged), 32'd0);
    chk("rst_wdog", 32'(watchdog_error), 32'd0);
    reset = 1'b0;
    tick(1);
    chk("idle_hold", 32'(core_state), 32'd0);

    // Non-memory instruction: states 1..6 then FETCH with PC 1
    thread_enable = 4'b1111; start = 1'b1;
    tick(1); chk("t1_fetch", 32'(core_state), 32'd1);
    start = 1'b0;
    tick(1); chk("t1_decode", 32'(core_state), 32'd2);
    tick(1); chk("t1_request", 32'(core_state), 32'd3);
    tick(1); chk("t1_wait", 32'(core_state), 32'd4);
    tick(1); chk("t1_execute", 32'(core_state), 32'd5);
    tick(1); chk("t1_update", 32'(core_state), 32'd6);
    chk("t1_pc_before", 32'(current_pc), 32'h00);
    tick(1); chk("t1_refetch", 32'(core_state), 32'd1);
    chk("t1_pc", 32'(current_pc), 32'h01);
    chk("t1_div", 32'(diverged), 32'd0);

    // FETCH holds while fetch_valid is low
    fetch_valid = 1'b0;
    tick(2); chk("fetch_hold", 32'(core_state), 32'd1);
    fetch_valid = 1'b1;

    // Load stall: thread 2 busy for 5 WAIT cycles
    next_pc = 32'h02020202; lsu_busy = 4'b0100;
    tick(3); chk("t2_wait1", 32'(core_state), 32'd4);
    for (int k = 2; k <= 5; k++) begin
      tick(1); chk($sformatf("t2_wait%0d", k), 32'(core_state), 32'd4);
    end
    lsu_busy = 4'b0000;
    tick(1); chk("t2_execute", 32'(core_state), 32'd5);
    tick(2); chk("t2_pc", 32'(current_pc), 32'h02);

    // RET: DONE, PC held, start high does not relaunch, start low returns to IDLE
    decoded_ret = 1'b1; next_pc = 32'h03030303;
    tick(5); chk("t4_update", 32'(core_state), 32'd6);
    start = 1'b1;
    tick(1); chk("t4_done_state", 32'(core_state), 32'd7);
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_pc_held", 32'(current_pc), 32'h02);
    tick(3); chk("t4_done_stay", 32'(core_state), 32'd7);
    chk("t4_done_still", 32'(done), 32'd1);
    start = 1'b0;
    tick(1); chk("t4_idle", 32'(core_state), 32'd0);
    chk("t4_done_clr", 32'(done), 32'd0);

    // Disabled thread's busy bit ignored: WAIT lasts 1 cycle
    decoded_ret = 1'b0; thread_enable = 4'b0011; lsu_busy = 4'b1000;
    next_pc = 32'h04040404; start = 1'b1;
    tick(1); chk("t3_fetch", 32'(core_state), 32'd1);
    chk("t3_pc_zero", 32'(current_pc), 32'h00);
    start = 1'b0;
    tick(3); chk("t3_wait", 32'(core_state), 32'd4);
    tick(1); chk("t3_execute", 32'(core_state), 32'd5);
    tick(2); chk("t3_pc", 32'(current_pc), 32'h04);
    decoded_ret = 1'b1;
    tick(6); chk("t3_done", 32'(core_state), 32'd7);
    decoded_ret = 1'b0;
    tick(1); chk("t3_idle", 32'(core_state), 32'd0);

    // Divergence: lowest enabled thread wins, flag sticky until next launch
    thread_enable = 4'b0110; lsu_busy = 4'b0000;
    next_pc = {8'h00, 8'h09, 8'h05, 8'hAA}; start = 1'b1;
    tick(1); start = 1'b0;
    tick(6); chk("t5_state", 32'(core_state), 32'd1);
    chk("t5_pc", 32'(current_pc), 32'h05);
    chk("t5_div", 32'(diverged), 32'd1);
    next_pc = {8'h00, 8'h07, 8'h07, 8'hAA};
    tick(6); chk("t5_pc2", 32'(current_pc), 32'h07);
    chk("t5_div_sticky", 32'(diverged), 32'd1);
    decoded_ret = 1'b1;
    tick(6); chk("t5_done", 32'(done), 32'd1);
    chk("t5_div_in_done", 32'(diverged), 32'd1);
    decoded_ret = 1'b0;
    tick(1); chk("t5_idle", 32'(core_state), 32'd0);

    // Empty mask launch goes straight to DONE and clears divergence
    thread_enable = 4'b0000; start = 1'b1;
    tick(1); chk("zm_state", 32'(core_state), 32'd7);
    chk("zm_done", 32'(done), 32'd1);
    chk("zm_div_clr", 32'(diverged), 32'd0);
    start = 1'b0;
    tick(1); chk("zm_idle", 32'(core_state), 32'd0);

    // PC wrap setup then a stall with every thread busy
    thread_enable = 4'b1111; next_pc = 32'h33333333; start = 1'b1;
    tick(1); start = 1'b0;
    tick(6); chk("t6_pc", 32'(current_pc), 32'h33);
    lsu_busy = 4'b1111;
    tick(3); chk("t6_wait", 32'(core_state), 32'd4);
`ifdef SCHED_WATCHDOG_EN
    tick(9); chk("t6_wait10", 32'(core_state), 32'd4);
    chk("t6_no_err_yet", 32'(watchdog_error), 32'd0);
    tick(1); chk("t6_done_state", 32'(core_state), 32'd7);
    chk("t6_wdog", 32'(watchdog_error), 32'd1);
    chk("t6_done", 32'(done), 32'd1);
    chk("t6_pc_held", 32'(current_pc), 32'h33);
`else
    tick(20); chk("t6_stall", 32'(core_state), 32'd4);
    chk("t6_no_wdog", 32'(watchdog_error), 32'd0);
    chk("t6_not_done", 32'(done), 32'd0);
`endif

    // Asynchronous reset without a clock edge
    #2 reset = 1'b1;
    #1;
    chk("ar_state", 32'(core_state), 32'd0);
    chk("ar_pc", 32'(current_pc), 32'd0);
    chk("ar_done", 32'(done), 32'd0);
    chk("ar_wdog", 32'(watchdog_error), 32'd0);
    chk("ar_div", 32'(diverged), 32'd0);
    lsu_busy = 4'b0000;
    tick(1); reset = 1'b0;
    tick(1); chk("ar_idle", 32'(core_state), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errs);
    $finish;
  end

endmodule
